// File: rtl/sl_pkg.sv
// Shared SL transceiver constants: FIFO word modifiers, widths and the
// write-arbiter state encoding.
package sl_pkg;

   localparam logic [1:0] SL_MOD_CONFIG  = 2'd0;
   localparam logic [1:0] SL_MOD_DATA    = 2'd1;
   localparam logic [1:0] SL_MOD_STATUS  = 2'd2;
   localparam logic [1:0] SL_MOD_CHANNEL = 2'd3;

   localparam int SL_FIFO_WIDTH = 34;

   localparam int ARB_IDLE_B  = 0;
   localparam int ARB_WRITE_B = 1;
   localparam int ARB_GUARD_B = 2;

   typedef enum logic [2:0] {
      ARB_IDLE  = 3'b001,
      ARB_WRITE = 3'b010,
      ARB_GUARD = 3'b100
   } arb_state_e;

endpackage

// File: rtl/sl_rr_picker.sv
// Rotate-priority encoder: first set request searching upward from
// last+1 modulo N. Shared by the SL FIFO write and read sides.
module sl_rr_picker #(
   parameter int N  = 3,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [N-1:0]  win_oh,
   output logic [IW-1:0] win_idx,
   output logic          any
);

   // Walk offsets from farthest to nearest so the nearest set bit wins.
   always_comb begin
      win_oh  = '0;
      win_idx = '0;
      for (int k = N; k >= 1; k--) begin
         if (req[(int'(last) + k) % N]) begin
            win_oh = '0;
            win_oh[(int'(last) + k) % N] = 1'b1;
            win_idx = IW'((int'(last) + k) % N);
         end
      end
      any = |req;
   end

endmodule

// File: rtl/sl_fifo_write_arbiter.sv
// Round-robin arbiter sharing the SL async-FIFO write port.
// Define SL_ARB_STRICT_PRIO_EN to give requester 0 absolute priority.
module sl_fifo_write_arbiter
   import sl_pkg::*;
#(
   parameter int NUM_REQ    = 3,
   parameter int DATA_WIDTH = SL_FIFO_WIDTH,
   parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
   input  logic                          pclk,
   input  logic                          preset_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          fifo_write_full,
   output logic [DATA_WIDTH-1:0]         fifo_write_data,
   output logic                          fifo_write_inc,
   output logic [ID_WIDTH-1:0]           grant_id,
   output logic                          busy
);

   arb_state_e            state;
   logic [ID_WIDTH-1:0]   last_grant;
   logic [NUM_REQ-1:0]    pick_req;
   logic [NUM_REQ-1:0]    pick_oh;
   logic [ID_WIDTH-1:0]   pick_idx;
   logic                  pick_any;
   logic [NUM_REQ-1:0]    sel_oh;
   logic [ID_WIDTH-1:0]   sel_idx;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  upd_last;
   logic                  grant;

`ifdef SL_ARB_STRICT_PRIO_EN
   // Requester 0 bypasses the pointer; the rest rotate among themselves.
   assign pick_req = {req_valid[NUM_REQ-1:1], 1'b0};

   always_comb begin
      if (req_valid[0]) begin
         sel_oh  = '0;
         sel_oh[0] = 1'b1;
         sel_idx = '0;
      end else begin
         sel_oh  = pick_oh;
         sel_idx = pick_idx;
      end
   end

   assign upd_last = (sel_idx != '0);
`else
   assign pick_req = req_valid;
   assign sel_oh   = pick_oh;
   assign sel_idx  = pick_idx;
   assign upd_last = 1'b1;
`endif

   sl_rr_picker #(
      .N  (NUM_REQ),
      .IW (ID_WIDTH)
   ) u_picker (
      .req     (pick_req),
      .last    (last_grant),
      .win_oh  (pick_oh),
      .win_idx (pick_idx),
      .any     (pick_any)
   );

   assign sel_data  = req_data[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];
   assign grant     = (state == ARB_IDLE) & (|req_valid) & ~fifo_write_full;
   assign req_ready = grant ? sel_oh : '0;

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         state           <= ARB_IDLE;
         last_grant      <= ID_WIDTH'(NUM_REQ - 1);
         fifo_write_data <= '0;
         fifo_write_inc  <= 1'b0;
         grant_id        <= '0;
         busy            <= 1'b0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (grant) begin
                  fifo_write_data <= sel_data;
                  fifo_write_inc  <= 1'b1;
                  grant_id        <= sel_idx;
                  busy            <= 1'b1;
                  state           <= ARB_WRITE;
                  if (upd_last)
                     last_grant <= sel_idx;
               end
            end
            ARB_WRITE: begin
               fifo_write_inc <= 1'b0;
               state          <= ARB_GUARD;
            end
            // Spacer so the FIFO full flag reflects the push before regranting.
            ARB_GUARD: begin
               busy  <= 1'b0;
               state <= ARB_IDLE;
            end
            default: begin
               fifo_write_inc <= 1'b0;
               busy           <= 1'b0;
               state          <= ARB_IDLE;
            end
         endcase
      end
   end

   logic unused_ok;
   assign unused_ok = pick_any;

endmodule
